// File: rtl/instruction_cache.sv
// Direct-mapped, read-only instruction cache: 8 lines of 16 B, 10-bit byte address.
// Misses fetch the whole block from instruction memory, install it, then complete the fetch.
module instruction_cache (
  input  logic         clock,
  input  logic         reset,
  input  logic         read,
  input  logic [9:0]   address,
  output logic [31:0]  readinst,
  output logic         busywait,
  output logic         mem_read,
  output logic [5:0]   mem_address,
  input  logic [127:0] mem_readdata,
  input  logic         mem_busywait
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEM_READ = 2'd1,
    UPDATE   = 2'd2
  } state_t;

  state_t state, next_state;

  logic [7:0]   valid;
  logic [2:0]   tags [8];
  logic [127:0] data [8];

  logic [2:0] tag;
  logic [2:0] index;
  logic [1:0] offset;
  logic       hit;
  logic       unused_bits;

  always_comb begin
    tag         = address[9:7];
    index       = address[6:4];
    offset      = address[3:2];
    unused_bits = ^address[1:0];
    hit         = valid[index] && (tags[index] == tag);
    readinst    = data[index][{offset, 5'd0} +: 32];
  end

  always_comb begin
    next_state  = state;
    busywait    = 1'b0;
    mem_read    = 1'b0;
    mem_address = address[9:4];
    case (state)
      IDLE: begin
        // Qualified by reset so the stall drops immediately while reset is held.
        busywait = reset && read && !hit;
        if (read && !hit) next_state = MEM_READ;
      end
      MEM_READ: begin
        busywait = 1'b1;
        mem_read = 1'b1;
        if (!mem_busywait) next_state = UPDATE;
      end
      UPDATE: begin
        busywait   = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      valid <= '0;
    end else begin
      state <= next_state;
      if (state == UPDATE) valid[index] <= 1'b1;
    end
  end

  // Tag and data storage carry no reset; they are meaningless until valid is set.
  always_ff @(posedge clock) begin
    if (state == UPDATE) begin
      data[index] <= mem_readdata;
      tags[index] <= tag;
    end
  end

endmodule

// File: doc/instruction_cache.md
# instruction_cache

Direct-mapped, read-only instruction cache between the CPU fetch stage and the 16-byte-block instruction memory. It serves 32-bit instruction fetches from eight cached 128-bit blocks. On a miss it acts as the initiator of the memory's read/busywait block protocol: it fetches the whole block, installs it, then completes the fetch. The CPU stalls on `busywait`; the memory is never accessed on a hit.

## Interface
- No parameters. Geometry is fixed: 8 lines × 16 B, 10-bit byte address, tag = address[9:7], index = address[6:4], word offset = address[3:2]. address[1:0] is ignored because fetches are word-aligned.
- `clock` — input, 1 — single clock; all state updates on its rising edge.
- `reset` — input, 1 — asynchronous, active-low. While low: all valid bits cleared, FSM forced to IDLE.
- `read` — input, 1 — CPU fetch request, level-sensitive.
- `address` — input, 10 — CPU byte address (PC). Held stable by the CPU while `busywait` is 1.
- `readinst` — output, 32 — fetched instruction word.
- `busywait` — output, 1 — CPU stall request.
- `mem_read` — output, 1 — block read request to instruction memory.
- `mem_address` — output, 6 — block address {tag, index}.
- `mem_readdata` — input, 128 — block from memory. Byte n of the block is in bits [8n+7:8n].
- `mem_busywait` — input, 1 — memory busy. It rises combinationally with `mem_read` and falls when the block is valid.

## Operation
- Storage per line: `valid` (1 bit), `tag` (3 bits), `data` (128 bits). Only `valid` is reset; `tag` and `data` are don't-care until filled.
- `hit` = valid[index] & (tag[index] == address[9:7]). This is combinational.
- `readinst` selects word address[3:2] of data[index]: word w = bits [32w+31:32w]. It is combinational and valid whenever `hit` is 1; its value is don't-care otherwise.
- FSM states:
  - **IDLE**:
    - `busywait` = read & !hit.
    - `mem_read` = 0.
    - On a clock edge with read & !hit → MEM_READ.
  - **MEM_READ**:
    - `busywait` = 1.
    - `mem_read` = 1, `mem_address` = address[9:4].
    - On a clock edge with !mem_busywait → UPDATE; otherwise stay.
  - **UPDATE**:
    - `busywait` = 1, `mem_read` = 0.
    - On the clock edge: data[index] ← mem_readdata, tag[index] ← address[9:7], valid[index] ← 1.
    - Then → IDLE. The fetch now hits, so `busywait` falls in IDLE.
- In every state other than MEM_READ, `mem_address` = address[9:4]; its value there is don't-care.
- `read` = 0 in IDLE: no action, `busywait` = 0.
- `read` dropping during MEM_READ/UPDATE is ignored; the fill completes.
- A conflict miss (same index, different tag) overwrites the line. No write-back is needed because the cache is read-only.

## Timing
- Reset values: `busywait` = 0, `mem_read` = 0, state = IDLE, all valid = 0. `readinst` is don't-care with no valid lines.
- Hit latency: 0 cycles. `busywait` stays 0 and `readinst` is valid in the same cycle as `address`.
- Miss latency, counted from the edge that leaves IDLE:
  - `mem_read` is high for ≥1 cycle (until the first edge that samples `mem_busywait` = 0).
  - Then 1 UPDATE cycle.
  - `busywait` falls on the first IDLE cycle after UPDATE.
  - Total stall = memory latency (in cycles) + 2.
- `mem_readdata` is sampled only on the UPDATE edge. It is only trusted after `mem_busywait` has fallen.
- `mem_read` must drop at the UPDATE entry edge. This prevents the memory from starting a second access.
- Reset asserted mid-fill (MEM_READ or UPDATE):
  - Immediately: state → IDLE, `mem_read` = 0, all valid = 0.
  - The partially fetched block is never installed.
  - After reset releases, the pending fetch misses again.
- Reset released coincident with a clock edge: that edge performs no transition.

## Test plan
- **Cold miss.** Reset, then read=1, address=0x000; memory block 0 = words {0x11111111, 0x22222222, 0x33333333, 0x44444444}. Required:
  - `busywait` 1 immediately.
  - `mem_read` 1 with `mem_address`=0.
  - After the fill, `busywait` 0 and `readinst`=0x11111111.
  - Total stall = memory latency + 2 cycles.
- **Hits in a filled block.** After the cold miss, step address through 0x004, 0x008, 0x00C. Required: `readinst` = 0x22222222, 0x33333333, 0x44444444; `busywait` never 1; `mem_read` never 1.
- **Conflict miss.** Address=0x080 (index 0, tag 1). Required:
  - Miss with `mem_address`=0x08; the line is refilled.
  - Returning to 0x000 then misses again with `mem_address`=0x00.
- **Independent lines.** Fill index 0 and index 5 (address 0x050). Required: alternating 0x000/0x050 then hits with no `mem_read`.
- **Reset mid-fill.** Pull `reset` low during MEM_READ. Required:
  - `mem_read` and `busywait` drop asynchronously.
  - After release, address 0x000 misses (valid was cleared).
- **Idle.** read=0 with any address. Required: `busywait` 0, `mem_read` 0, no state change across 10 cycles.
